mips_mc_ctrl: RTL

- Multicycle MIPS control FSM; sequences the shared 32-bit datapath registers (PC, IR, MDR, A, B, ALUOut) and a single unified memory.
- Produces per-state register write enables and mux selects.
- Waits on a memory ready handshake, with timeout.
- Counts retired instructions.

---
 rtl/mips_ctrl_pkg.sv | 46 ++++
 rtl/mips_mem_wait_timer.sv | 31 +++
 rtl/mips_mc_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, state encodings, mux selects.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that talk to the unified memory and therefore wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready inside one memory state; flags the last allowed wait cycle.
// Latency: at_limit is combinational from the registered count; count updates one cycle after inc.
// Backpressure: none; clr has priority over inc and restarts the count at zero.
module mips_mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    // The count never passes MEM_WAIT_MAX-1: at that value the access either completes or times out,
    // and both cases clear the counter.
    localparam logic [7:0] LIMIT = 8'(MEM_WAIT_MAX - 1);

    logic [7:0] cnt;

    // Wait-cycle counter with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences datapath enables/mux selects, counts retired instructions.
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles; +1 per cycle of mem_ready=0 in a memory state.
// Backpressure: memory states hold on mem_ready=0 up to MEM_WAIT_MAX cycles, then abandon and raise bus_err.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             bus_err,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_o
);

    state_t state;
    logic   is_sw;
    logic   mem_state;
    logic   at_limit;
    logic   timeout;
    logic   wait_stay;
    logic   retire;
    logic   op_legal;

    mips_mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!wait_stay),
        .inc      (wait_stay),
        .at_limit (at_limit)
    );

    // Wait/timeout qualification and end-of-instruction detection.
    always_comb begin
        mem_state = is_mem_state(state);
        timeout   = mem_state && !mem_ready && at_limit;
        wait_stay = mem_state && !mem_ready && !at_limit;
        op_legal  = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ)   || (opcode == OP_J)  || (opcode == OP_ADDI);
        retire    = (state == S_MEM_WB) || (state == S_R_WB) || (state == S_BRANCH) ||
                    (state == S_JUMP)   || (state == S_ADDI_WB) ||
                    ((state == S_MEM_WRITE) && mem_ready);
    end

    // State sequencing plus the sticky error flag, latched lw/sw selector and retired counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            is_sw   <= 1'b0;
            bus_err <= 1'b0;
            retired <= '0;
        end else begin
            if (timeout) bus_err <= 1'b1;
            if (retire)  retired <= retired + CNT_W'(1);
            case (state)
                S_FETCH: begin
                    if (mem_ready)    state <= S_DECODE;
                    else if (timeout) state <= S_FETCH;
                end
                S_DECODE: begin
                    is_sw <= (opcode == OP_SW);
                    case (opcode)
                        OP_RTYPE:     state <= S_R_EXEC;
                        OP_LW, OP_SW: state <= S_MEM_ADDR;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
                        OP_ADDI:      state <= S_ADDI_EXEC;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR:  state <= is_sw ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ: begin
                    if (mem_ready)    state <= S_MEM_WB;
                    else if (timeout) state <= S_FETCH;
                end
                S_MEM_WRITE: begin
                    if (mem_ready || timeout) state <= S_FETCH;
                end
                S_R_EXEC:    state <= S_R_WB;
                S_ADDI_EXEC: state <= S_ADDI_WB;
                default:     state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the control word; memory-state enables qualified by mem_ready, all zero in reset.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = SRCB_SEXT_SH2;
                    illegal_op = !op_legal;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_SEXT;
                end
                S_MEM_READ: begin
                    mem_read  = 1'b1;
                    iord      = 1'b1;
                    mdr_write = mem_ready;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = zero;
                    pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_SEXT;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign state_o = state;

endmodule
